// File: rtl/io_ctrl_pkg.sv
// Shared defaults and FSM encoding for the duty/GPIO ramp controller.
package io_ctrl_pkg;

    localparam int DEF_DUTY_W = 8;
    localparam int DEF_RATE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } ramp_state_e;

endpackage

// File: rtl/rate_timer.sv
// Step-interval down-counter: load wins over count, counts down to zero and parks there.
module rate_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Reload on request, otherwise decrement while enabled and nonzero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   count <= '0;
        else if (load)                count <= load_val;
        else if (en && count != '0)   count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps a shared duty/GPIO register toward a target in fixed steps, one write
// every rate+1 cycles; host writes pass straight through when idle.
module pwm_ramp_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int DUTY_W = DEF_DUTY_W,
    parameter int RATE_W = DEF_RATE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [3:0]        cmd_step,
    input  logic [RATE_W-1:0] cmd_rate,
    input  logic              cmd_abort,
    input  logic              host_we,
    input  logic [DUTY_W-1:0] host_wdata,
    output logic              duty_we,
    output logic [DUTY_W-1:0] duty_wdata,
    output logic              busy,
    output logic              done
);

    ramp_state_e       state, state_nxt;
    logic [DUTY_W-1:0] tgt_q, duty_nxt, next_val, step_w;
    logic [3:0]        step_q, step_eff;
    logic [RATE_W-1:0] rate_q, tmr_val;
    logic [DUTY_W:0]   up_sum, dn_lim;
    logic              we_nxt, done_nxt, latch_cmd, tmr_load, tmr_en, tmr_zero;

    assign cmd_ready = (state == ST_IDLE) & ena & ~host_we;
    assign busy      = (state != ST_IDLE);
    assign tmr_en    = ena & (state == ST_WAIT);

    // Next duty value: move by step toward target, clamp at target so we never
    // overshoot; the wider sums keep the compare free of wrap-around.
    always_comb begin
        step_eff = (step_q == 4'd0) ? 4'd1 : step_q;
        step_w   = DUTY_W'(step_eff);
        up_sum   = {1'b0, duty_wdata} + (DUTY_W+1)'(step_eff);
        dn_lim   = {1'b0, tgt_q} + (DUTY_W+1)'(step_eff);
        next_val = tgt_q;
        if (tgt_q > duty_wdata) begin
            if (up_sum < {1'b0, tgt_q}) next_val = up_sum[DUTY_W-1:0];
        end else begin
            if ({1'b0, duty_wdata} > dn_lim) next_val = duty_wdata - step_w;
        end
    end

    // Next-state and registered-output decode; ena low leaves everything held
    // and forces the strobes low.
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty_wdata;
        we_nxt    = 1'b0;
        done_nxt  = 1'b0;
        latch_cmd = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = rate_q;
        if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (host_we) begin
                        duty_nxt = host_wdata;
                        we_nxt   = 1'b1;
                    end else if (cmd_valid) begin
                        latch_cmd = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = cmd_rate;
                        if (cmd_target == duty_wdata) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cmd_abort) begin
                        state_nxt = ST_IDLE;
                    end else if (tmr_zero) begin
                        duty_nxt = next_val;
                        we_nxt   = 1'b1;
                        if (next_val == tgt_q) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            tmr_load = 1'b1;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Duty register, strobes and the latched command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_wdata <= '0;
            duty_we    <= 1'b0;
            done       <= 1'b0;
            tgt_q      <= '0;
            step_q     <= '0;
            rate_q     <= '0;
        end else begin
            duty_wdata <= duty_nxt;
            duty_we    <= we_nxt;
            done       <= done_nxt;
            if (latch_cmd) begin
                tgt_q  <= cmd_target;
                step_q <= cmd_step;
                rate_q <= cmd_rate;
            end
        end
    end

    rate_timer #(.W(RATE_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Randomized + directed bench for pwm_ramp_ctrl against a write-list reference model.
module tb_pwm_ramp_ctrl;

    localparam int DUTY_W = 8;
    localparam int RATE_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena, cmd_valid, cmd_ready, cmd_abort, host_we;
    logic [DUTY_W-1:0] cmd_target, host_wdata, duty_wdata;
    logic [3:0]        cmd_step;
    logic [RATE_W-1:0] cmd_rate;
    logic              duty_we, busy, done;

    int total = 0;
    int bad   = 0;

    // Reference model: on accept the whole list of writes is computed up front,
    // then released one per rate+1 enabled cycles.
    int m_cur, m_cnt, m_rate;
    bit m_busy, m_donep, m_we, m_done;
    int pend[$];

    pwm_ramp_ctrl #(.DUTY_W(DUTY_W), .RATE_W(RATE_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_rate   (cmd_rate),
        .cmd_abort  (cmd_abort),
        .host_we    (host_we),
        .host_wdata (host_wdata),
        .duty_we    (duty_we),
        .duty_wdata (duty_wdata),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cur = 0; m_cnt = 0; m_rate = 0;
        m_busy = 0; m_donep = 0; m_we = 0; m_done = 0;
        pend.delete();
    endtask

    // One rising edge of the reference model, using the inputs currently driven.
    task automatic model_step();
        int v, st, t;
        m_we = 0; m_done = 0;
        if (!ena) return;
        if (m_donep) begin
            m_donep = 0; m_busy = 0;
        end else if (m_busy) begin
            if (cmd_abort) begin
                m_busy = 0; pend.delete();
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_cur = pend.pop_front();
                    m_we  = 1;
                    if (pend.size() == 0) begin m_done = 1; m_donep = 1; end
                    else m_cnt = m_rate + 1;
                end
            end
        end else if (host_we) begin
            m_cur = int'(host_wdata); m_we = 1;
        end else if (cmd_valid) begin
            v  = m_cur;
            t  = int'(cmd_target);
            st = (cmd_step == 0) ? 1 : int'(cmd_step);
            while (v != t) begin
                if (t > v) v = (v + st > t) ? t : v + st;
                else       v = (v - st < t) ? t : v - st;
                pend.push_back(v);
            end
            m_busy = 1; m_rate = int'(cmd_rate); m_cnt = m_rate + 1;
            if (pend.size() == 0) begin m_done = 1; m_donep = 1; end
        end
    endtask

    task automatic set_in(input bit e, input bit cv, input int tg, input int stp, input int rt,
                          input bit ab, input bit hw, input int hd);
        ena = e; cmd_valid = cv; cmd_target = tg[DUTY_W-1:0]; cmd_step = stp[3:0];
        cmd_rate = rt[RATE_W-1:0]; cmd_abort = ab; host_we = hw; host_wdata = hd[DUTY_W-1:0];
    endtask

    task automatic tick();
        #1;
        chk("cmd_ready", cmd_ready, !m_busy && ena && !host_we);
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("duty_we", duty_we, m_we);
        chk("duty_wdata", duty_wdata, m_cur);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic host_wr(input int d);
        set_in(1, 0, 0, 0, 0, 0, 1, d); tick();
    endtask

    task automatic cmd(input int tg, input int stp, input int rt);
        set_in(1, 1, tg, stp, rt, 0, 0, 0); tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"},    duty_we, 0);
        chk({tag, "_wdata"}, duty_wdata, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
    endtask

    initial begin
        model_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // 0 -> 10, step 3, rate 2: 3,6,9,10 three cycles apart.
        cmd(10, 3, 2);
        idle(14);

        // Same ramp aborted after the write of 6.
        host_wr(0);
        cmd(10, 3, 2);
        idle(6);
        chk("abort_pre_val", duty_wdata, 6);
        set_in(1, 0, 0, 0, 0, 1, 0, 0); tick();
        chk("abort_idle", busy, 0);
        idle(4);

        // Host 200, ramp down to 190 step 4 rate 0: 196,192,190 back to back.
        host_wr(200);
        cmd(190, 4, 0);
        idle(5);
        chk("down_final", duty_wdata, 190);

        // Step 0 behaves as 1.
        cmd(192, 0, 1);
        idle(6);

        // Enable dropped for 5 cycles mid-wait.
        host_wr(0);
        cmd(10, 3, 2);
        idle(4);
        for (int i = 0; i < 5; i++) begin set_in(0, 1, 77, 1, 0, 0, 1, 55); tick(); end
        idle(12);

        // Host write racing a command, then host write while busy.
        set_in(1, 1, 50, 2, 0, 0, 1, 40); tick();
        chk("race_host", duty_wdata, 40);
        cmd(46, 2, 1);
        set_in(1, 0, 0, 0, 0, 0, 1, 99); tick();
        set_in(1, 1, 0, 1, 0, 0, 0, 0); tick();
        idle(8);
        // Abort in idle does nothing.
        set_in(1, 0, 0, 0, 0, 1, 0, 0); tick();

        // Saturation at the rails.
        host_wr(250);
        cmd(255, 15, 0);
        idle(3);
        host_wr(5);
        cmd(0, 15, 0);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            int r, tg;
            r  = $urandom_range(0, 99);
            tg = (m_cur ^ $urandom_range(1, 255)) & 255;
            set_in(($urandom_range(0, 9) != 0), (r < 25), tg, $urandom_range(0, 15),
                   $urandom_range(0, 3), ($urandom_range(0, 39) == 0),
                   ($urandom_range(0, 9) == 0), $urandom_range(0, 255));
            tick();
        end

        // Reset in the middle of a ramp.
        idle(3);
        host_wr(0);
        cmd(200, 1, 3);
        idle(7);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter DUTY_W, default 8, meaning the duty/GPIO data width.
REQ-002 SHALL have parameter RATE_W, default 8, meaning the width of the step-interval counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port ena, input, 1, global enable; low freezes all state.
REQ-006 SHALL have port cmd_valid, input, 1, ramp command offered.
REQ-007 SHALL have port cmd_ready, output, 1, command accepted this cycle when high with cmd_valid.
REQ-008 SHALL have port cmd_target, input, DUTY_W, final duty value.
REQ-009 SHALL have port cmd_step, input, 4, increment per step; 0 is treated as 1.
REQ-010 SHALL have port cmd_rate, input, RATE_W, extra wait cycles per step.
REQ-011 SHALL have port cmd_abort, input, 1, cancels an active ramp.
REQ-012 SHALL have port host_we, input, 1, direct host write request.
REQ-013 SHALL have port host_wdata, input, DUTY_W, direct host write data.
REQ-014 SHALL have port duty_we, output, 1, single-cycle write strobe to the shared GPIO/duty register.
REQ-015 SHALL have port duty_wdata, output, DUTY_W, registered last-written duty value, also used as current duty.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port done, output, 1, single-cycle pulse on normal ramp completion.

Function
REQ-018 SHALL implement an FSM with states IDLE, WAIT and DONE; all outputs are registered or pure state decode.
REQ-019 SHALL drive cmd_ready = (state==IDLE) & ena & ~host_we, so a host write wins over a simultaneous command.
REQ-020 On host_we & ena in IDLE, SHALL register duty_wdata<=host_wdata and duty_we<=1 (one-cycle latency) and stay in IDLE.
REQ-021 SHALL silently drop host_we while busy, with no write and no state change.
REQ-022 On command accept, SHALL latch target, step and rate, load timer<=cmd_rate, and go to WAIT.
REQ-023 If an accepted target equals duty_wdata, SHALL go directly to DONE with no write.
REQ-024 In WAIT with ena high, SHALL decrement timer when it is nonzero.
REQ-025 In WAIT when timer==0, SHALL register duty_wdata<=next and duty_we<=1, where next = cur±step saturated at target (no overshoot, no wrap past 0 or 2^DUTY_W-1).
REQ-026 After a REQ-025 write, SHALL go to DONE if next==target, else reload timer<=rate and stay in WAIT.
REQ-027 SHALL make the first write strobe appear rate+1 cycles after the accept edge, then one every rate+1 cycles.
REQ-028 The final write's duty_we and done SHALL be high in the same cycle; DONE SHALL last one cycle and then return to IDLE.
REQ-029 On cmd_abort while busy, SHALL go to IDLE at the next edge with no write and no done pulse, and duty_wdata SHALL hold; abort in IDLE has no effect.
REQ-030 While ena is low, SHALL freeze FSM, timer and duty_wdata, hold duty_we=0 and done=0, and keep cmd_ready=0.
REQ-031 SHALL ignore cmd_valid while busy; the command is neither queued nor accepted.

Reset
REQ-032 On rst_n low, SHALL immediately set state=IDLE, timer=0, duty_wdata=0, duty_we=0, done=0 and busy=0, including mid-ramp.
REQ-033 SHALL set cmd_ready to 1 from the first cycle after reset release, provided ena=1 and host_we=0.

Structure
REQ-034 SHALL place DUTY_W, RATE_W defaults and the FSM state encoding in a shared package, io_ctrl_pkg.
REQ-035 SHALL implement the interval counter as sub-module rate_timer (load, enable, zero flag).
REQ-036 Outputs duty_we and duty_wdata SHALL connect directly to the GPIO register write port (we/wdata).

Verification
REQ-037 SHALL cover: cur=0, target=10, step=3, rate=2 -> writes 3,6,9,10, strobes 3 cycles apart, done with the write of 10.
REQ-038 SHALL cover: host write 200, then target=190, step=4, rate=0 -> writes 196,192,190 on consecutive cycles, then done.
REQ-039 SHALL cover: step=0, target=cur+2, rate=1 -> writes cur+1, cur+2 two cycles apart.
REQ-040 SHALL cover: abort after the second write of REQ-037 -> IDLE next cycle, duty_wdata=6, no done pulse.
REQ-041 SHALL cover: ena low for 5 cycles mid-WAIT -> no strobes during the gap, and ramp timing resumes exactly.
REQ-042 SHALL cover: host_we and cmd_valid together in IDLE -> host data written, cmd_ready=0; host_we while busy -> dropped.
